// File: rtl/qspi_ram_ctrl.sv
// qspi_ram_ctrl: single-byte read/write controller for a PSRAM already in QPI mode.
// Each transfer is 8-bit command, 24-bit address, then data, all nibble-wide and
// MSB-first. One nibble takes a 2-cycle slot: phase A has ram_clk low and io
// updating, phase B has ram_clk high and io held.
// Ports:
//   clock, reset        system clock, async active-high reset
//   in_addr, in_wdata   request address / write byte, latched on acceptance
//   in_rd, in_wr        one-cycle request pulses (read wins when both are high)
//   out_rdata           last read byte; out_rvalid pulses when it updates
//   out_busy            transaction in progress
//   out_ram_*           PSRAM serial clock, chip select, io out / output enable
//   in_ram_io_i         PSRAM io in
module qspi_ram_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic [23:0] in_addr,
  input  logic [7:0]  in_wdata,
  input  logic        in_rd,
  input  logic        in_wr,
  output logic [7:0]  out_rdata,
  output logic        out_rvalid,
  output logic        out_busy,
  output logic        out_ram_clk,
  output logic        out_ram_csn,
  output logic [3:0]  out_ram_io_o,
  output logic [3:0]  out_ram_io_oe,
  input  logic [3:0]  in_ram_io_i
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RDATA = 3'd4;
  localparam logic [2:0] S_WDATA = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [2:0]  slot_q, slot_d;     // slots left in the current state, minus one
  logic        phase_q, phase_d;   // 0 = phase A, 1 = phase B
  logic [39:0] sh_q, sh_d;         // {cmd, addr, wdata}; top nibble is on the bus
  logic        rd_q, rd_d;
  logic [3:0]  nib_q, nib_d;       // first read nibble
  logic [7:0]  rdata_q, rdata_d;

  logic slot_end, xfer, drive;
  assign slot_end = phase_q && (slot_q == 3'd0);
  assign xfer     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign drive    = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_WDATA);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    phase_d = 1'b0;
    sh_d    = sh_q;
    rd_d    = rd_q;
    nib_d   = nib_q;
    rdata_d = rdata_q;
    if (xfer) begin
      // phase toggles every cycle; the end of a slot returns it to phase A
      phase_d = ~phase_q;
      if (phase_q && !slot_end) slot_d = slot_q - 3'd1;
      if (phase_q && drive) sh_d = {sh_q[35:0], 4'h0};
    end
    case (state_q)
      S_IDLE: begin
        if (in_rd || in_wr) begin
          state_d = S_CMD;
          slot_d  = 3'd1;
          rd_d    = in_rd;
          sh_d    = {(in_rd ? 8'hEB : 8'h38), in_addr, in_wdata};
        end
      end
      S_CMD: if (slot_end) begin
        state_d = S_ADDR;
        slot_d  = 3'd5;
      end
      S_ADDR: if (slot_end) begin
        state_d = rd_q ? S_WAIT : S_WDATA;
        slot_d  = rd_q ? 3'd5 : 3'd1;
      end
      S_WAIT: if (slot_end) begin
        state_d = S_RDATA;
        slot_d  = 3'd1;
      end
      S_RDATA: begin
        if (phase_q) nib_d = in_ram_io_i;
        // second nibble goes straight into the result so it is visible in DONE
        if (slot_end) begin
          rdata_d = {nib_q, in_ram_io_i};
          state_d = S_DONE;
        end
      end
      S_WDATA: if (slot_end) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      slot_q  <= 3'd0;
      phase_q <= 1'b0;
      sh_q    <= 40'd0;
      rd_q    <= 1'b0;
      nib_q   <= 4'd0;
      rdata_q <= 8'd0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      phase_q <= phase_d;
      sh_q    <= sh_d;
      rd_q    <= rd_d;
      nib_q   <= nib_d;
      rdata_q <= rdata_d;
    end
  end

  // Bus outputs decode from state so an async reset drops csn/oe immediately.
  assign out_ram_csn   = ~xfer;
  assign out_ram_clk   = xfer & phase_q;
  assign out_ram_io_oe = {4{drive}};
  assign out_ram_io_o  = drive ? sh_q[39:36] : 4'h0;
  assign out_busy      = (state_q != S_IDLE);
  assign out_rvalid    = (state_q == S_DONE) && rd_q;
  assign out_rdata     = rdata_q;
endmodule

// File: doc/qspi_ram_ctrl.md
QSPI_RAM_CTRL -- requirements
Module: qspi_ram_ctrl

Interface
REQ-001 SHALL have port clock, input, 1: single system clock; all state on its rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-high; clears all state immediately, independent of clock.
REQ-003 SHALL have port in_addr, input, 24: byte address, sampled with the request.
REQ-004 SHALL have port in_wdata, input, 8: write byte, sampled with the request.
REQ-005 SHALL have port in_rd, input, 1: read request, one-cycle pulse.
REQ-006 SHALL have port in_wr, input, 1: write request, one-cycle pulse.
REQ-007 SHALL have port out_rdata, output, 8: read byte, held until the next read completes.
REQ-008 SHALL have port out_rvalid, output, 1: one-cycle pulse when out_rdata is updated.
REQ-009 SHALL have port out_busy, output, 1: high while a transaction is in progress.
REQ-010 SHALL have port out_ram_clk, output, 1: PSRAM serial clock.
REQ-011 SHALL have port out_ram_csn, output, 1: PSRAM chip select, active-low.
REQ-012 SHALL have port out_ram_io_o, output, 4: QSPI data out, io3..io0.
REQ-013 SHALL have port out_ram_io_oe, output, 4: per-pin output enable, 1 = drive.
REQ-014 SHALL have port in_ram_io_i, input, 4: QSPI data in, io3..io0.

Function
REQ-015 SHALL use QPI framing on all 4 lines (PSRAM already in QPI mode): 8-bit command, 24-bit address, data; nibbles MSB-first.
REQ-016 SHALL transfer one nibble per 2-cycle slot: phase A ram_clk=0 with io updated; phase B ram_clk=1 with io held; read data sampled at the end of phase B.
REQ-017 SHALL implement states IDLE -> CMD (2 slots) -> ADDR (6 slots) -> [read: WAIT (6 slots, oe=0000) -> RDATA (2 slots, oe=0000)] or [write: WDATA (2 slots, oe=1111)] -> DONE (1 cycle) -> IDLE.
REQ-018 SHALL use command 0xEB for reads and 0x38 for writes.
REQ-019 SHALL, in IDLE, accept a request on the cycle in_rd or in_wr is high, latch in_addr and in_wdata, and enter CMD on the next edge.
REQ-020 SHALL give in_rd priority when in_rd and in_wr are high in the same cycle; the write is dropped.
REQ-021 SHALL ignore in_rd and in_wr while out_busy=1; no queueing.
REQ-022 SHALL assert out_busy from the cycle after acceptance through DONE inclusive.
REQ-023 SHALL hold out_ram_csn low from the first CMD cycle through the last data cycle: 32 cycles for a read, 20 cycles for a write.
REQ-024 SHALL drive out_ram_csn high, out_ram_clk low and out_ram_io_oe=0000 in DONE, guaranteeing at least 1 cycle of csn high between transactions.
REQ-025 SHALL drive out_ram_io_oe=1111 during CMD, ADDR and WDATA only.
REQ-026 SHALL, for a read, update out_rdata with {first nibble, second nibble} and pulse out_rvalid during the DONE cycle.
REQ-027 SHALL never pulse out_rvalid for a write.
REQ-028 SHALL count slots with a modular counter reloaded at each state entry; no wrap carries across states.
REQ-029 SHALL pass the address through without alignment or wrap checks; 0xFFFFFF is legal.

Reset
REQ-030 SHALL, while reset=1, force state=IDLE, out_ram_csn=1, out_ram_clk=0, out_ram_io_o=0000, out_ram_io_oe=0000, out_busy=0, out_rvalid=0, out_rdata=0x00.
REQ-031 SHALL abort any in-flight transaction on reset (csn high immediately, no rvalid) and accept a new request on the first IDLE cycle after reset deasserts.

Verification
REQ-032 SHALL pass: read at in_addr=0x123456 with the model returning 0xA5 -> io_o nibbles E,B,1,2,3,4,5,6; csn low 32 cycles; out_rdata=0xA5 with a one-cycle out_rvalid at cycle 33 after acceptance.
REQ-033 SHALL pass: write of 0x3C at 0x000010 -> nibbles 3,8,0,0,0,0,1,0,3,C; csn low 20 cycles; no out_rvalid; out_busy clears after DONE.
REQ-034 SHALL pass: in_rd and in_wr pulsed together -> command 0xEB issued; no write occurs.
REQ-035 SHALL pass: in_wr pulsed while out_busy=1 -> ignored; the transaction count is unchanged.
REQ-036 SHALL pass: reset asserted in the 5th WAIT slot -> csn=1 and oe=0000 in the same cycle; no rvalid; a read issued after release completes normally.
REQ-037 SHALL pass: back-to-back reads at 0xFFFFFF then 0x000000 -> csn high for at least 1 cycle between them; both out_rdata values are correct.
